// File: rtl/retire_arbiter.sv
// Three-way round-robin arbiter for the ROB completion port, with a registered output beat.
// Optional macro BRANCH_PRIORITY_EN: requesters with flags bit 5 set win ahead of the rest.
module retire_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [2:0]  req_valid,
    output logic [2:0]  req_ready,
    input  logic [11:0] req_robid,
    input  logic [23:0] req_flags,
    input  logic [23:0] req_wbs,
    input  logic [23:0] req_value,
    output logic        rob_transmit,
    output logic [3:0]  robid,
    output logic [7:0]  flags,
    output logic [7:0]  wbs,
    output logic [7:0]  value
);

    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned ID_W    = 4;
    localparam int unsigned DATA_W  = 8;

    typedef struct packed {
        logic [ID_W-1:0]   robid;
        logic [DATA_W-1:0] flags;
        logic [DATA_W-1:0] wbs;
        logic [DATA_W-1:0] value;
    } beat_t;

    logic [1:0]         ptr;
    logic [1:0]         ptr_nxt;
    logic [1:0]         gidx;
    logic [2:0]         sum;
    logic               found;
    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] grant;
    beat_t              sel_beat;
    beat_t              out_beat;
`ifdef BRANCH_PRIORITY_EN
    logic [NUM_REQ-1:0] branch;
`endif

    // Candidate set: branch completions first when priority mode is built in.
    always_comb begin
        cand = req_valid;
`ifdef BRANCH_PRIORITY_EN
        branch = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            branch[i] = req_valid[i] & req_flags[DATA_W*i + 5];
        end
        if (|branch) begin
            cand = branch;
        end
`endif
    end

    // Search from ptr in modulo-3 order; flush and reset suppress every grant.
    always_comb begin
        grant = '0;
        gidx  = 2'd0;
        found = 1'b0;
        sum   = 3'd0;
        if (rst && !flush) begin
            for (int k = 0; k < int'(NUM_REQ); k++) begin
                sum = 3'(ptr) + 3'(k);
                if (sum >= 3'(NUM_REQ)) begin
                    sum = sum - 3'(NUM_REQ);
                end
                if (!found && cand[2'(sum)]) begin
                    found = 1'b1;
                    gidx  = 2'(sum);
                end
            end
        end
        if (found) begin
            grant[gidx] = 1'b1;
        end
        ptr_nxt = (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
    end

    assign req_ready = grant;

    always_comb begin
        case (gidx)
            2'd1:    sel_beat = beat_t'{req_robid[7:4],  req_flags[15:8],  req_wbs[15:8],  req_value[15:8]};
            2'd2:    sel_beat = beat_t'{req_robid[11:8], req_flags[23:16], req_wbs[23:16], req_value[23:16]};
            default: sel_beat = beat_t'{req_robid[3:0],  req_flags[7:0],   req_wbs[7:0],   req_value[7:0]};
        endcase
    end

    // Output stage: beat valid one cycle after the transfer, payload holds when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr          <= 2'd0;
            rob_transmit <= 1'b0;
            out_beat     <= '0;
        end else if (found) begin
            ptr          <= ptr_nxt;
            rob_transmit <= 1'b1;
            out_beat     <= sel_beat;
        end else begin
            rob_transmit <= 1'b0;
        end
    end

    assign robid = out_beat.robid;
    assign flags = out_beat.flags;
    assign wbs   = out_beat.wbs;
    assign value = out_beat.value;

endmodule

// File: doc/retire_arbiter.md
RETIRE_ARBITER -- requirements
Module: retire_arbiter

Shares the single ROB completion port among three execution units (0=ALU, 1=LSU, 2=BRU) with round-robin arbitration and a registered output stage.

Interface
REQ-001 The block SHALL have no parameters; requester count is fixed at 3, robid 4 bits, flags/wbs/value 8 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 flush  input  1  pipeline flush; blocks all grants this cycle.
REQ-005 req_valid  input  3  bit i: requester i has a completion pending.
REQ-006 req_ready  output  3  bit i: requester i granted this cycle (combinational, one-hot or zero).
REQ-007 req_robid  input  12  requester i robid at bits [4i+3:4i].
REQ-008 req_flags  input  24  requester i flags at [8i+7:8i]; bit 7 = WB, bit 5 = Branch.
REQ-009 req_wbs  input  24  requester i wbs at [8i+7:8i].
REQ-010 req_value  input  24  requester i value at [8i+7:8i].
REQ-011 rob_transmit  output  1  registered; completion beat valid to ROB.
REQ-012 robid, flags, wbs, value  output  4/8/8/8  registered payload of granted requester.

Function
REQ-013 A transfer SHALL occur for requester i in cycle N iff req_valid[i] and req_ready[i] are both 1 at the rising edge ending cycle N.
REQ-014 req_ready SHALL be zero whenever flush=1, rst=0 or no req_valid bit is set.
REQ-015 Round-robin pointer ptr SHALL hold a value in {0,1,2}; search order is ptr, ptr+1, ptr+2 (mod 3); the first valid requester is granted.
REQ-016 After a grant to i, ptr SHALL become (i+1) mod 3; with no grant, ptr SHALL be unchanged.
REQ-017 At most one requester SHALL be granted per cycle; the ROB accepts one beat per cycle without back-pressure.
REQ-018 Latency SHALL be exactly 1 cycle: a transfer in cycle N drives rob_transmit=1 with the granted payload in cycle N+1.
REQ-019 A cycle with no transfer SHALL drive rob_transmit=0 in the following cycle; payload registers SHALL hold their last value.
REQ-020 Payload fields SHALL be forwarded unmodified (no masking of wbs for non-WB flags).
REQ-021 flush SHALL NOT cancel a beat already in the output register; it only suppresses the grant in the flush cycle; ptr is unchanged by flush.
REQ-022 A requester holding req_valid=1 without grant SHALL be granted within 3 cycles in which flush=0 (starvation bound, non-priority mode).

Reset
REQ-023 While rst=0: rob_transmit=0, robid=0, flags=0, wbs=0, value=0, ptr=0, req_ready=0, taking effect immediately (asynchronous).
REQ-024 Reset asserted mid-operation SHALL drop any in-flight output beat; first grant after release follows ptr=0 order.
REQ-025 Release of rst SHALL take effect on the first rising edge with rst=1; no extra idle cycles.

Configuration
REQ-026 Macro BRANCH_PRIORITY_EN SHALL select branch-first arbitration.
REQ-027 Defined: among valid requesters, those with flags bit 5 set SHALL be considered first in ptr order; only if none exist do others compete; ptr update per REQ-016.
REQ-028 Undefined: pure round-robin per REQ-015; flags do not affect arbitration; REQ-022 bound applies.

Verification
REQ-029 rst released, req_valid=111 held, robids 1/2/3 for req 0/1/2 -> req_ready 001,010,100,001 in successive cycles; robid out 1,2,3,1 one cycle later, rob_transmit=1 each cycle.
REQ-030 Only req_valid[1]=1, robid=5, flags=8'h80, wbs=8'hA5, value=8'h55 -> req_ready=010 same cycle; next cycle rob_transmit=1, robid=5, flags=80, wbs=A5, value=55; following cycle rob_transmit=0.
REQ-031 req_valid=111 with flush=1 for one cycle -> req_ready=000, rob_transmit=0 next cycle, grant order after flush identical to pre-flush ptr.
REQ-032 ptr=0, req0 flags=8'h80, req2 flags=8'h20, both valid -> with BRANCH_PRIORITY_EN req_ready=100; without, req_ready=001.
REQ-033 rst driven low between clock edges while rob_transmit=1 -> rob_transmit and all payload outputs 0 immediately; after release with req_valid=110 first grant is req 1.
